// File: rtl/alu_sequencer.sv
// ALU-class instruction sequencer: latches IR on handshake, steps FETCH2/LDB/RS1/EXEC, traps undefined encodings.
// Done 3 (imm) / 4 (reg) cycles after handshake, trap 1 cycle; ir_ready_o only in IDLE, so fetch stalls otherwise.
module alu_sequencer #(
  parameter int XLEN    = 64,
  parameter int RMASK_W = XLEN / 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ir_valid_i,
  input  logic [31:0]        ir_i,
  output logic               ir_ready_o,
  output logic               ra_ir1_o,
  output logic               ra_ir2_o,
  output logic               ra_ird_o,
  output logic               alub_imm6i_o,
  output logic               alub_imm12_o,
  output logic               alub_rf_o,
  output logic               alua_rf_o,
  output logic               rf_alu_o,
  output logic [RMASK_W-1:0] rmask_o,
  output logic               cflag_1_o,
  output logic               sum_en_o,
  output logic               and_en_o,
  output logic               xor_en_o,
  output logic               invB_en_o,
  output logic               lsh_en_o,
  output logic               rsh_en_o,
  output logic               ltu_en_o,
  output logic               lts_en_o,
  output logic               sx32_en_o,
  output logic               done_o,
  output logic               trap_o
);

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic       HAS_W        = (XLEN == 64);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH2, S_LDB, S_RS1, S_EXEC, S_TRAP
  } state_t;

  typedef struct packed {
    logic cflag_1;
    logic sum;
    logic and_op;
    logic xor_op;
    logic inv_b;
    logic lsh;
    logic rsh;
    logic ltu;
    logic lts;
    logic sx32;
  } alu_ctl_t;

  state_t      state, state_nxt;
  logic [31:0] ir_q;

  // Legality of the offered word; only steers next state, never an output.
  logic [6:0] in_op;
  logic [2:0] in_f3;
  logic [6:0] in_f7;
  logic       in_is_imm, in_is_reg, in_imm_ok, in_reg_ok;

  assign in_op = ir_i[6:0];
  assign in_f3 = ir_i[14:12];
  assign in_f7 = ir_i[31:25];

  assign in_is_imm = (in_op == OPC_OP_IMM) || (HAS_W && (in_op == OPC_OP_IMM32));
  assign in_is_reg = (in_op == OPC_OP)     || (HAS_W && (in_op == OPC_OP32));

  always_comb begin
    in_imm_ok = 1'b1;
    if (in_f3 == 3'b001 || in_f3 == 3'b101) begin
      // 64-bit OP-IMM shifts use a 6-bit shamt, so IR[25] is a shamt bit there.
      if (HAS_W && in_op == OPC_OP_IMM)
        in_imm_ok = (ir_i[31:26] == 6'b000000) ||
                    (in_f3 == 3'b101 && ir_i[31:26] == 6'b010000);
      else
        in_imm_ok = (in_f7 == 7'b0000000) ||
                    (in_f3 == 3'b101 && in_f7 == 7'b0100000);
    end
  end

  assign in_reg_ok = (in_f7 == 7'b0000000) ||
                     (in_f7 == 7'b0100000 && (in_f3 == 3'b000 || in_f3 == 3'b101));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= S_IDLE;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && ir_valid_i)
        ir_q <= ir_i;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (ir_valid_i) begin
          if (in_is_reg && in_reg_ok)      state_nxt = S_FETCH2;
          else if (in_is_imm && in_imm_ok) state_nxt = S_LDB;
          else                             state_nxt = S_TRAP;
        end
      end
      S_FETCH2: state_nxt = S_LDB;
      S_LDB:    state_nxt = S_RS1;
      S_RS1:    state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_IDLE;
      S_TRAP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Latched-IR views: bit 5 separates register forms, bit 3 the *-32 forms.
  logic [2:0] q_f3;
  logic       q_reg, q_w, q_alt, q_shift;
  logic       unused_ir;

  assign q_f3      = ir_q[14:12];
  assign q_reg     = ir_q[5];
  assign q_w       = ir_q[3];
  assign q_alt     = ir_q[30];
  assign q_shift   = (q_f3 == 3'b001) || (q_f3 == 3'b101);
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:6], ir_q[4], ir_q[2:0]};

  alu_ctl_t alu;

  always_comb begin
    alu = '0;
    unique case (q_f3)
      3'b000: begin
        alu.sum     = 1'b1;
        alu.cflag_1 = q_reg && q_alt;
        alu.inv_b   = q_reg && q_alt;
      end
      3'b001: alu.lsh = 1'b1;
      3'b010: begin alu.cflag_1 = 1'b1; alu.inv_b = 1'b1; alu.lts = 1'b1; end
      3'b011: begin alu.cflag_1 = 1'b1; alu.inv_b = 1'b1; alu.ltu = 1'b1; end
      3'b100: alu.xor_op = 1'b1;
      3'b101: begin alu.rsh = 1'b1; alu.cflag_1 = q_alt; end
      3'b110: begin alu.and_op = 1'b1; alu.xor_op = 1'b1; end
      default: alu.and_op = 1'b1;
    endcase
    alu.sx32 = q_w;
  end

  always_comb begin
    ir_ready_o   = 1'b0;
    ra_ir1_o     = 1'b0;
    ra_ir2_o     = 1'b0;
    ra_ird_o     = 1'b0;
    alub_imm6i_o = 1'b0;
    alub_imm12_o = 1'b0;
    alub_rf_o    = 1'b0;
    alua_rf_o    = 1'b0;
    rf_alu_o     = 1'b0;
    rmask_o      = '0;
    cflag_1_o    = 1'b0;
    sum_en_o     = 1'b0;
    and_en_o     = 1'b0;
    xor_en_o     = 1'b0;
    invB_en_o    = 1'b0;
    lsh_en_o     = 1'b0;
    rsh_en_o     = 1'b0;
    ltu_en_o     = 1'b0;
    lts_en_o     = 1'b0;
    sx32_en_o    = 1'b0;
    done_o       = 1'b0;
    trap_o       = 1'b0;
    unique case (state)
      S_IDLE:   ir_ready_o = reset_i;
      S_FETCH2: ra_ir2_o = 1'b1;
      S_LDB: begin
        alub_rf_o    = q_reg;
        alub_imm6i_o = !q_reg && q_shift;
        alub_imm12_o = !q_reg && !q_shift;
      end
      S_RS1:    ra_ir1_o = 1'b1;
      S_EXEC: begin
        alua_rf_o = 1'b1;
        ra_ird_o  = 1'b1;
        rf_alu_o  = 1'b1;
        done_o    = 1'b1;
        rmask_o   = '1;
        cflag_1_o = alu.cflag_1;
        sum_en_o  = alu.sum;
        and_en_o  = alu.and_op;
        xor_en_o  = alu.xor_op;
        invB_en_o = alu.inv_b;
        lsh_en_o  = alu.lsh;
        rsh_en_o  = alu.rsh;
        ltu_en_o  = alu.ltu;
        lts_en_o  = alu.lts;
        sx32_en_o = alu.sx32;
      end
      S_TRAP:   trap_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: XLEN=64 and XLEN=32 instances against a per-cycle trace model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v64, v32;
  logic [31:0] ir64, ir32;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready, ra1, ra2, rad, imm6, imm12, brf, arf, rfalu;
    logic [3:0] rmask;
    logic       cflag, sum, and_e, xor_e, invb, lsh, rsh, ltu, lts, sx32;
    logic       done, trap;
  } ov_t;

  logic a_rdy, a_r1, a_r2, a_rd, a_i6, a_i12, a_brf, a_arf, a_wr;
  logic a_cf, a_sum, a_and, a_xor, a_inv, a_lsh, a_rsh, a_ltu, a_lts, a_sx, a_done, a_trap;
  logic [3:0] a_mask;
  logic b_rdy, b_r1, b_r2, b_rd, b_i6, b_i12, b_brf, b_arf, b_wr;
  logic b_cf, b_sum, b_and, b_xor, b_inv, b_lsh, b_rsh, b_ltu, b_lts, b_sx, b_done, b_trap;
  logic [1:0] b_mask;

  alu_sequencer #(.XLEN(64)) u64 (
    .clk_i(clk), .reset_i(reset_i), .ir_valid_i(v64), .ir_i(ir64), .ir_ready_o(a_rdy),
    .ra_ir1_o(a_r1), .ra_ir2_o(a_r2), .ra_ird_o(a_rd),
    .alub_imm6i_o(a_i6), .alub_imm12_o(a_i12), .alub_rf_o(a_brf), .alua_rf_o(a_arf),
    .rf_alu_o(a_wr), .rmask_o(a_mask), .cflag_1_o(a_cf), .sum_en_o(a_sum), .and_en_o(a_and),
    .xor_en_o(a_xor), .invB_en_o(a_inv), .lsh_en_o(a_lsh), .rsh_en_o(a_rsh), .ltu_en_o(a_ltu),
    .lts_en_o(a_lts), .sx32_en_o(a_sx), .done_o(a_done), .trap_o(a_trap)
  );

  alu_sequencer #(.XLEN(32)) u32 (
    .clk_i(clk), .reset_i(reset_i), .ir_valid_i(v32), .ir_i(ir32), .ir_ready_o(b_rdy),
    .ra_ir1_o(b_r1), .ra_ir2_o(b_r2), .ra_ird_o(b_rd),
    .alub_imm6i_o(b_i6), .alub_imm12_o(b_i12), .alub_rf_o(b_brf), .alua_rf_o(b_arf),
    .rf_alu_o(b_wr), .rmask_o(b_mask), .cflag_1_o(b_cf), .sum_en_o(b_sum), .and_en_o(b_and),
    .xor_en_o(b_xor), .invB_en_o(b_inv), .lsh_en_o(b_lsh), .rsh_en_o(b_rsh), .ltu_en_o(b_ltu),
    .lts_en_o(b_lts), .sx32_en_o(b_sx), .done_o(b_done), .trap_o(b_trap)
  );

  ov_t o64, o32;
  assign o64 = {a_rdy, a_r1, a_r2, a_rd, a_i6, a_i12, a_brf, a_arf, a_wr, a_mask,
                a_cf, a_sum, a_and, a_xor, a_inv, a_lsh, a_rsh, a_ltu, a_lts, a_sx, a_done, a_trap};
  assign o32 = {b_rdy, b_r1, b_r2, b_rd, b_i6, b_i12, b_brf, b_arf, b_wr, 2'b00, b_mask,
                b_cf, b_sum, b_and, b_xor, b_inv, b_lsh, b_rsh, b_ltu, b_lts, b_sx, b_done, b_trap};

  int total = 0;
  int bad   = 0;
  ov_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ov_t cur(input bit sel);
    return sel ? o32 : o64;
  endfunction

  // Architectural legality, straight from the encoding rules.
  function automatic bit legal(input int xlen, input logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    bit sra_f7 = (f7 == 7'b0000000) || (f3 == 3'd5 && f7 == 7'b0100000);
    if (op == 7'b0010011) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (xlen == 64) return (w[31:26] == 6'd0) || (f3 == 3'd5 && w[31:26] == 6'b010000);
        return sra_f7;
      end
      return 1'b1;
    end
    if (op == 7'b0011011) begin
      if (xlen != 64) return 1'b0;
      if (f3 == 3'd1 || f3 == 3'd5) return sra_f7;
      return 1'b1;
    end
    if (op == 7'b0110011 || (op == 7'b0111011 && xlen == 64))
      return (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
    return 1'b0;
  endfunction

  // Expected output vector for each cycle after the handshake edge.
  function automatic void model(input int xlen, input logic [31:0] w);
    ov_t v;
    logic [2:0] f3 = w[14:12];
    bit is_reg = (w[6:0] == 7'b0110011) || (w[6:0] == 7'b0111011);
    exp_q.delete();
    if (!legal(xlen, w)) begin
      v = '0; v.trap = 1'b1; exp_q.push_back(v);
      return;
    end
    if (is_reg) begin
      v = '0; v.ra2 = 1'b1; exp_q.push_back(v);
    end
    v = '0;
    if (is_reg)                        v.brf  = 1'b1;
    else if (f3 == 3'd1 || f3 == 3'd5) v.imm6 = 1'b1;
    else                               v.imm12 = 1'b1;
    exp_q.push_back(v);
    v = '0; v.ra1 = 1'b1; exp_q.push_back(v);
    v = '0;
    v.arf = 1'b1; v.rad = 1'b1; v.rfalu = 1'b1; v.done = 1'b1;
    v.rmask = (xlen == 64) ? 4'hF : 4'h3;
    case (f3)
      3'd0: begin v.sum = 1'b1; if (is_reg && w[30]) begin v.cflag = 1'b1; v.invb = 1'b1; end end
      3'd1: v.lsh = 1'b1;
      3'd2: begin v.cflag = 1'b1; v.invb = 1'b1; v.lts = 1'b1; end
      3'd3: begin v.cflag = 1'b1; v.invb = 1'b1; v.ltu = 1'b1; end
      3'd4: v.xor_e = 1'b1;
      3'd5: begin v.rsh = 1'b1; v.cflag = w[30]; end
      3'd6: begin v.and_e = 1'b1; v.xor_e = 1'b1; end
      default: v.and_e = 1'b1;
    endcase
    v.sx32 = (w[6:0] == 7'b0011011) || (w[6:0] == 7'b0111011);
    exp_q.push_back(v);
  endfunction

  // Entered on a negedge with the chosen DUT idle; leaves on the negedge it is idle again.
  task automatic run(input bit sel, input logic [31:0] w, input string nm);
    ov_t idle_v;
    idle_v = '0;
    idle_v.ready = 1'b1;
    model(sel ? 32 : 64, w);
    chk({nm, "_idle"}, 32'(cur(sel)), 32'(idle_v));
    if (sel) begin v32 = 1'b1; ir32 = w; end
    else     begin v64 = 1'b1; ir64 = w; end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      v32 = 1'b0; v64 = 1'b0;
      ir32 = $urandom; ir64 = $urandom;
      chk($sformatf("%s_c%0d", nm, i + 1), 32'(cur(sel)), 32'(exp_q[i]));
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 7))
      0, 1:    w[6:0] = 7'b0010011;
      2:       w[6:0] = 7'b0011011;
      3, 4:    w[6:0] = 7'b0110011;
      5:       w[6:0] = 7'b0111011;
      6:       w[6:0] = 7'b0010011 ^ 7'(1 << $urandom_range(0, 6));
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'b0000000;
      1: w[31:25] = 7'b0100000;
      2: w[31:25] = 7'b0000001;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ov_t idle_v;
    idle_v = '0;
    idle_v.ready = 1'b1;
    reset_i = 1'b0; v64 = 1'b0; v32 = 1'b0; ir64 = '0; ir32 = '0;
    #12;
    chk("rst64", 32'(o64), 32'h0);
    chk("rst32", 32'(o32), 32'h0);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);

    run(1'b0, 32'h04200093, "addi");
    run(1'b0, 32'h402081B3, "sub");
    run(1'b0, 32'h02101093, "slli64");
    run(1'b1, 32'h02101093, "slli32");
    run(1'b0, 32'h4030D09B, "sraiw");
    run(1'b0, 32'h4230D09B, "sraiw_bad");
    run(1'b1, 32'h4030D09B, "w32_trap");
    run(1'b1, 32'h402081B3, "sub32");

    ir64 = 32'h04200093; ir32 = 32'h04200093;
    repeat (5) begin
      @(negedge clk);
      chk("idle64", 32'(o64), 32'(idle_v));
      chk("idle32", 32'(o32), 32'(idle_v));
    end

    // Asynchronous reset during RS1 of an ADDI.
    v64 = 1'b1; ir64 = 32'h04200093;
    @(negedge clk); v64 = 1'b0;
    @(negedge clk);
    chk("rs1_seen", 32'(a_r1), 32'h1);
    #2 reset_i = 1'b0;
    #1 chk("rst_async", 32'(o64), 32'h0);
    @(posedge clk);
    #1 chk("rst_hold", 32'(o64), 32'h0);
    @(negedge clk);
    reset_i = 1'b1;
    #1 chk("rst_release", 32'(o64), 32'(idle_v));
    @(negedge clk);
    run(1'b0, 32'h04200093, "addi_after_rst");

    for (int n = 0; n < 400; n++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run(bit'($urandom_range(0, 1)), rand_ir(), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
